// File: rtl/enigma_step_ctrl.sv
// Rotor stepping initiator: accepts a plaintext letter, pulses the rotor step enables
// (including the middle-rotor double step), waits for the chain to settle and returns ciphertext.
module enigma_step_ctrl #(
    parameter logic [4:0]  NOTCH_R       = 5'd16,
    parameter logic [4:0]  NOTCH_M       = 5'd4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_load,
    output logic        load_config,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_char,
    input  logic [4:0]  pos_r,
    input  logic [4:0]  pos_m,
    output logic        step_r,
    output logic        step_m,
    output logic        step_l,
    output logic [4:0]  chain_char,
    input  logic [4:0]  enc_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_char,
    output logic        err_char,
    output logic [15:0] char_count
);

    localparam int unsigned    CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, OUT} state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          accept;

    assign in_ready = (state == IDLE) && !cfg_load;
    assign accept   = in_valid && in_ready;

    // Step enables are decoded from the registered state so the notch compare
    // sees the rotor positions present during the STEP cycle (pre-step).
    assign step_r = (state == STEP);
    assign step_m = step_r && ((pos_r == NOTCH_R) || (pos_m == NOTCH_M));
    assign step_l = step_r && (pos_m == NOTCH_M);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            load_config <= 1'b0;
            err_char    <= 1'b0;
            chain_char  <= '0;
            out_valid   <= 1'b0;
            out_char    <= '0;
            char_count  <= '0;
        end else begin
            load_config <= 1'b0;
            err_char    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        load_config <= 1'b1;
                        state       <= LOAD;
                    end else if (accept) begin
                        if (in_char < 5'd26) begin
                            chain_char <= in_char;
                            state      <= STEP;
                        end else begin
                            err_char <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    char_count <= '0;
                    state      <= IDLE;
                end
                STEP: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        out_char  <= enc_char;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        char_count <= char_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed plus randomized bench for enigma_step_ctrl; expectations come from a
// transaction-level model of the stepping rules, latency and letter count.
module tb_enigma_step_ctrl;

    localparam logic [4:0] NOTCH_R = 5'd16;
    localparam logic [4:0] NOTCH_M = 5'd4;
    localparam int         SETTLE  = 2;

    logic        clk = 1'b0;
    logic        reset, cfg_load, in_valid, out_ready;
    logic [4:0]  in_char, pos_r, pos_m, enc_char;
    logic        load_config, in_ready, step_r, step_m, step_l, out_valid, err_char;
    logic [4:0]  chain_char, out_char;
    logic [15:0] char_count;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    enigma_step_ctrl #(
        .NOTCH_R(NOTCH_R),
        .NOTCH_M(NOTCH_M),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .load_config(load_config),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .pos_r(pos_r), .pos_m(pos_m),
        .step_r(step_r), .step_m(step_m), .step_l(step_l),
        .chain_char(chain_char), .enc_char(enc_char),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .err_char(err_char), .char_count(char_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] rnd_letter();
        logic [4:0] v;
        v = 5'($urandom_range(0, 25));
        return v;
    endfunction

    // One full letter: handshake, STEP cycle, SETTLE cycles, OUT with 'stall' refused cycles.
    task automatic do_letter(input logic [4:0] ch, input logic [4:0] pr, input logic [4:0] pm,
                             input logic [4:0] enc, input int stall);
        logic exp_m, exp_l;
        // Right rotor always moves; middle moves at the right notch or on its own notch
        // (double step); left moves only when the middle sits on its notch.
        exp_l = (pr == NOTCH_M) ? 1'b0 : 1'b0;
        exp_l = (pm == NOTCH_M);
        exp_m = exp_l || (pr == NOTCH_R);

        @(negedge clk);
        in_valid = 1'b1; in_char = ch; pos_r = pr; pos_m = pm; enc_char = rnd_letter();
        #1 chk("in_ready_idle", 16'(in_ready), 16'd1);

        @(negedge clk);
        in_valid = 1'b0; in_char = rnd_letter();
        chk("step_r", 16'(step_r), 16'd1);
        chk("step_m", 16'(step_m), 16'(exp_m));
        chk("step_l", 16'(step_l), 16'(exp_l));
        chk("chain_char", 16'(chain_char), 16'(ch));
        chk("in_ready_busy", 16'(in_ready), 16'd0);

        for (int s = 1; s <= SETTLE; s++) begin
            @(negedge clk);
            chk("settle_steps", {13'd0, step_r, step_m, step_l}, 16'd0);
            chk("settle_out_valid", 16'(out_valid), 16'd0);
            if (s == SETTLE) enc_char = enc;
        end

        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 16'(out_valid), 16'd1);
            chk("stall_out_char", 16'(out_char), 16'(enc));
            chk("stall_in_ready", 16'(in_ready), 16'd0);
            enc_char = rnd_letter();
        end

        @(negedge clk);
        chk("out_valid", 16'(out_valid), 16'd1);
        chk("out_char", 16'(out_char), 16'(enc));
        out_ready = 1'b1;

        @(negedge clk);
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        chk("done_out_valid", 16'(out_valid), 16'd0);
        chk("done_in_ready", 16'(in_ready), 16'd1);
        chk("char_count", char_count, 16'(exp_count));
        chk("chain_hold", 16'(chain_char), 16'(ch));
    endtask

    task automatic do_bad(input logic [4:0] ch);
        @(negedge clk);
        in_valid = 1'b1; in_char = ch;
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_char", 16'(err_char), 16'd1);
        chk("err_no_step", {13'd0, step_r, step_m, step_l}, 16'd0);
        chk("err_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        chk("err_pulse_end", 16'(err_char), 16'd0);
        chk("err_out_valid", 16'(out_valid), 16'd0);
        chk("err_count", char_count, 16'(exp_count));
    endtask

    task automatic do_load(input logic with_letter);
        @(negedge clk);
        cfg_load = 1'b1; in_valid = with_letter; in_char = 5'd7;
        #1 chk("load_in_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0;
        chk("load_config", 16'(load_config), 16'd1);
        chk("load_no_step", 16'(step_r), 16'd0);
        exp_count = 0;
        @(negedge clk);
        chk("load_pulse_end", 16'(load_config), 16'd0);
        chk("load_count", char_count, 16'd0);
        chk("load_ready", 16'(in_ready), 16'd1);
        chk("load_no_letter", {14'd0, step_r, out_valid}, 16'd0);
    endtask

    initial begin
        logic [4:0] pr, pm;
        reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_char = '0; pos_r = '0; pos_m = '0; enc_char = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_flags", {10'd0, load_config, out_valid, err_char, step_r, step_m, step_l}, 16'd0);
        chk("rst_count", char_count, 16'd0);
        chk("rst_chars", {6'd0, chain_char, out_char}, 16'd0);

        pos_r = 5'd0; pos_m = 5'd0;
        do_load(1'b0);

        do_letter(5'd0, 5'd5, 5'd0, 5'd9, 0);
        do_letter(rnd_letter(), 5'd16, 5'd2, rnd_letter(), 1);
        do_letter(rnd_letter(), 5'd3, 5'd4, rnd_letter(), 0);

        do_bad(5'd27);
        do_load(1'b1);

        do_letter(rnd_letter(), rnd_letter(), rnd_letter(), rnd_letter(), 10);

        // Reset while the letter is in SETTLE: it must vanish without output.
        @(negedge clk);
        in_valid = 1'b1; in_char = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        chk("abort_in_ready", 16'(in_ready), 16'd1);
        chk("abort_flags", {10'd0, load_config, out_valid, err_char, step_r, step_m, step_l}, 16'd0);
        chk("abort_count", char_count, 16'd0);
        chk("abort_chars", {6'd0, chain_char, out_char}, 16'd0);
        for (int i = 0; i < SETTLE + 4; i++) begin
            @(negedge clk);
            chk("abort_no_out", 16'(out_valid), 16'd0);
        end

        for (int n = 0; n < 30; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                do_bad(5'($urandom_range(26, 31)));
            end else if (sel == 1) begin
                do_load(1'($urandom_range(0, 1)));
            end else begin
                pr = ($urandom_range(0, 2) == 0) ? NOTCH_R : rnd_letter();
                pm = ($urandom_range(0, 2) == 0) ? NOTCH_M : rnd_letter();
                do_letter(rnd_letter(), pr, pm, rnd_letter(), int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
